// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_ctrl.
// RCA_SEQ_SUB_EN adds the in_sub request bit.
interface rca_seq_ctrl_if #(
    parameter int unsigned NCHUNK = 4
);
    localparam int unsigned W = 3 * NCHUNK;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef RCA_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

`ifdef RCA_SEQ_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`endif
endinterface

// File: rtl/rca_seq_ctrl.sv
// Chunk-serial adder: one 3-bit ripple-carry adder stepped LSB-first across NCHUNK slices.
// Optional subtract mode is enabled by defining RCA_SEQ_SUB_EN.
module rca (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    input  logic       cin_i,
    output logic [2:0] sum_o,
    output logic       cout_o
);
    logic [3:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int unsigned i = 0; i < 3; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[3];
    end
endmodule

module rca_seq_ctrl #(
    parameter int unsigned NCHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rca_seq_ctrl_if.slave bus
);
    localparam int unsigned W    = 3 * NCHUNK;
    localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
`ifdef RCA_SEQ_SUB_EN
    logic            sub_q;
`endif

    int unsigned     base;
    logic [2:0]      slice_a;
    logic [2:0]      slice_b;
    logic [2:0]      slice_sum;
    logic            slice_cout;

    always_comb begin
        base    = 3 * int'(idx_q);
        slice_a = opa_q[base +: 3];
`ifdef RCA_SEQ_SUB_EN
        slice_b = opb_q[base +: 3] ^ {3{sub_q}};
`else
        slice_b = opb_q[base +: 3];
`endif
    end

    rca u_rca (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_q   <= bus.in_a;
                        opb_q   <= bus.in_b;
                        idx_q   <= '0;
                        sum_q   <= '0;
`ifdef RCA_SEQ_SUB_EN
                        // Subtract = a + ~b + 1: the +1 rides in as the slice-0 carry.
                        sub_q   <= bus.in_sub;
                        carry_q <= bus.in_sub | bus.in_cin & ~bus.in_sub;
`else
                        carry_q <= bus.in_cin;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: 3] <= slice_sum;
                    carry_q          <= slice_cout;
                    if (idx_q == LAST) begin
                        cout_q  <= slice_cout;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule
